// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM state encoding, PC width and reset PC.
package cpu_defs;

   localparam int PC_W = 32;

   localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } fetch_state_t;

   // Instruction addresses must be word aligned (low two bits zero).
   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Loadable up/down counter with clear and a terminal-count flag.
// Priority: clear, then load, then count. tc compares against tc_val.
module fetch_timeout_ctr #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         en,
   input  logic         dn,
   input  logic [W-1:0] tc_val,
   output logic [W-1:0] cnt,
   output logic         tc
);

   // Counter register: clear has priority over load, load over counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (ld) begin
         cnt <= ld_val;
      end else if (en) begin
         cnt <= dn ? (cnt - W'(1)) : (cnt + W'(1));
      end
   end

   assign tc = (cnt == tc_val);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/ack read to instruction
// memory and holds the fetched word in the IR until it is consumed.
module if_fetch_unit
   import cpu_defs::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter int              TIMEOUT  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PC_W-1:0] next_pc,
   input  logic            pc_write,
   input  logic            fetch_start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [PC_W-1:0] imem_rdata,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] ir,
   output logic [PC_W-1:0] ir_pc,
   output logic            ir_valid,
   output logic            busy,
   output logic            fetch_err,
   output logic            align_err
);

   localparam int              CNT_W  = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

   fetch_state_t     state;
   fetch_state_t     state_nxt;
   logic [PC_W-1:0]  pend_pc;
   logic             pend_vld;
   logic [CNT_W-1:0] wait_cnt;
   logic             wait_tc;

   logic in_req;
   logic wr_ok;
   logic wr_bad;
   logic ack_take;
   logic tmo;
   logic leave_req;

   assign in_req    = (state == ST_REQ);
   assign wr_ok     = pc_write && is_word_aligned(next_pc[1:0]);
   assign wr_bad    = pc_write && !is_word_aligned(next_pc[1:0]);
   assign ack_take  = in_req && imem_ack;
   // The ack wins if it arrives in the very last allowed cycle.
   assign tmo       = in_req && !imem_ack && wait_tc;
   assign leave_req = ack_take || tmo;

   // Request signals decode straight from state so an async reset drops them at once.
   assign imem_req  = in_req;
   assign busy      = in_req;
   assign imem_addr = pc;

   // Counts REQ cycles without ack; held at zero outside REQ so every entry starts fresh.
   fetch_timeout_ctr #(
      .W (CNT_W)
   ) u_timeout_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (!in_req),
      .ld     (1'b0),
      .ld_val ('0),
      .en     (in_req && !imem_ack),
      .dn     (1'b0),
      .tc_val (TC_VAL),
      .cnt    (wait_cnt),
      .tc     (wait_tc)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; fetch_start inside REQ is deliberately ignored.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (fetch_start) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (imem_ack)     state_nxt = ST_DONE;
            else if (wait_tc) state_nxt = ST_IDLE;
         end
         ST_DONE: begin
            if (fetch_start) state_nxt = ST_REQ;
            else if (wr_ok)  state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // PC and pending register: writes during REQ are parked so imem_addr stays stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         pend_pc  <= '0;
         pend_vld <= 1'b0;
      end else if (in_req) begin
         if (leave_req) begin
            pend_vld <= 1'b0;
            // A write on the leaving edge is newer than anything parked.
            if (wr_ok) begin
               pc <= next_pc;
            end else if (pend_vld) begin
               pc <= pend_pc;
            end
         end else if (wr_ok) begin
            pend_pc  <= next_pc;
            pend_vld <= 1'b1;
         end
      end else if (wr_ok) begin
         pc <= next_pc;
      end
   end

   // Instruction register: loaded on ack, invalidated by a new fetch, a PC change or a timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir       <= '0;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
      end else if (ack_take) begin
         ir       <= imem_rdata;
         ir_pc    <= pc;
         ir_valid <= 1'b1;
      end else if (tmo) begin
         ir_valid <= 1'b0;
      end else if (!in_req && (fetch_start || wr_ok)) begin
         ir_valid <= 1'b0;
      end
   end

   // One-cycle error pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_err <= 1'b0;
         align_err <= 1'b0;
      end else begin
         fetch_err <= tmo;
         align_err <= wr_bad;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam int          TMO     = 16;

   logic        clk;
   logic        rst_n;
   logic [31:0] next_pc;
   logic        pc_write;
   logic        fetch_start;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic        ir_valid;
   logic        busy;
   logic        fetch_err;
   logic        align_err;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] e_pc, e_ir, e_ir_pc;
   logic        e_ir_valid, e_fetch_err, e_align_err;
   bit          m_busy;
   int          m_wait;
   logic [31:0] pend_q[$];

   if_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .next_pc     (next_pc),
      .pc_write    (pc_write),
      .fetch_start (fetch_start),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .pc          (pc),
      .ir          (ir),
      .ir_pc       (ir_pc),
      .ir_valid    (ir_valid),
      .busy        (busy),
      .fetch_err   (fetch_err),
      .align_err   (align_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      e_pc = RST_PC; e_ir = '0; e_ir_pc = '0;
      e_ir_valid = 0; e_fetch_err = 0; e_align_err = 0;
      m_busy = 0; m_wait = 0;
      pend_q.delete();
   endtask

   // One clock edge of the fetch unit, described at transaction level.
   task automatic model_edge();
      bit aligned;
      aligned = (next_pc[1:0] == 2'b00);
      e_fetch_err = 0;
      e_align_err = pc_write && !aligned;
      if (m_busy) begin
         if (imem_ack || m_wait == TMO - 1) begin
            if (imem_ack) begin
               e_ir = imem_rdata; e_ir_pc = e_pc; e_ir_valid = 1;
            end else begin
               e_fetch_err = 1; e_ir_valid = 0;
            end
            if (pc_write && aligned) e_pc = next_pc;
            else if (pend_q.size() > 0) e_pc = pend_q[0];
            pend_q.delete();
            m_busy = 0;
         end else begin
            m_wait++;
            if (pc_write && aligned) begin
               pend_q.delete();
               pend_q.push_back(next_pc);
            end
         end
      end else begin
         if (pc_write && aligned) begin
            e_pc = next_pc; e_ir_valid = 0;
         end
         if (fetch_start) begin
            m_busy = 1; m_wait = 0; e_ir_valid = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   task automatic clear_inputs();
      pc_write = 0; fetch_start = 0; imem_ack = 0; next_pc = '0; imem_rdata = '0;
   endtask

   task automatic test_reset();
      rst_n = 0; clear_inputs(); model_reset();
      #2;
      total++; if (pc !== RST_PC) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
      total++; if ({ir_valid, busy, fetch_err, align_err} !== 4'b0) begin bad++;
         $display("FAIL reset_flags: got %b want 0000", {ir_valid, busy, fetch_err, align_err}); end
      total++; if (ir !== 32'h0 || ir_pc !== 32'h0) begin bad++; $display("FAIL reset_ir: ir %h ir_pc %h want 0", ir, ir_pc); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1;
      tick();
   endtask

   task automatic test_first_fetch();
      fetch_start = 1;
      tick();
      fetch_start = 0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++;
         $display("FAIL first_req: req %b addr %h want 1 00000000", imem_req, imem_addr); end
      imem_ack = 1; imem_rdata = 32'h2008_0005;
      tick();
      imem_ack = 0;
      total++; if (ir !== 32'h2008_0005) begin bad++; $display("FAIL first_ir: got %h want 20080005", ir); end
      total++; if (ir_pc !== 32'h0 || ir_valid !== 1'b1) begin bad++;
         $display("FAIL first_irpc: ir_pc %h valid %b want 0 1", ir_pc, ir_valid); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL first_done_req: got %b want 0", imem_req); end
   endtask

   task automatic test_pc_write();
      pc_write = 1; next_pc = 32'h0000_0040;
      tick();
      pc_write = 0;
      total++; if (pc !== 32'h40 || ir_valid !== 1'b0) begin bad++;
         $display("FAIL pcw: pc %h ir_valid %b want 00000040 0", pc, ir_valid); end
      fetch_start = 1;
      tick();
      fetch_start = 0;
      total++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin bad++;
         $display("FAIL pcw_fetch: addr %h req %b want 00000040 1", imem_addr, imem_req); end
   endtask

   task automatic test_delayed_ack();
      logic [31:0] word;
      word = $urandom;
      tick();                        // now in 2nd REQ cycle
      pc_write = 1; next_pc = 32'h0000_0080;
      tick();
      pc_write = 0;
      total++; if (imem_addr !== 32'h40 || pc !== 32'h40) begin bad++;
         $display("FAIL dly_hold: addr %h pc %h want 00000040", imem_addr, pc); end
      tick(); tick(); tick();
      total++; if (imem_addr !== 32'h40 || busy !== 1'b1) begin bad++;
         $display("FAIL dly_hold2: addr %h busy %b want 00000040 1", imem_addr, busy); end
      imem_ack = 1; imem_rdata = word;
      tick();
      imem_ack = 0;
      total++; if (ir_pc !== 32'h40 || pc !== 32'h80) begin bad++;
         $display("FAIL dly_ack: ir_pc %h pc %h want 00000040 00000080", ir_pc, pc); end
      total++; if (ir !== word || ir_valid !== 1'b1) begin bad++;
         $display("FAIL dly_ir: ir %h valid %b want %h 1", ir, ir_valid, word); end
   endtask

   task automatic test_timeout();
      int n;
      fetch_start = 1;
      tick();
      fetch_start = 0;
      n = 0;
      while (imem_req === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      total++; if (n != TMO) begin bad++; $display("FAIL tmo_cycles: got %0d want %0d", n, TMO); end
      total++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0 || busy !== 1'b0) begin bad++;
         $display("FAIL tmo_flags: err %b req %b valid %b busy %b want 1 0 0 0", fetch_err, imem_req, ir_valid, busy); end
      tick();
      total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL tmo_pulse: got %b want 0", fetch_err); end
   endtask

   task automatic test_align();
      pc_write = 1; next_pc = 32'h0000_0042;
      tick();
      pc_write = 0;
      total++; if (align_err !== 1'b1 || pc !== 32'h80) begin bad++;
         $display("FAIL align: err %b pc %h want 1 00000080", align_err, pc); end
      tick();
      total++; if (align_err !== 1'b0) begin bad++; $display("FAIL align_pulse: got %b want 0", align_err); end
   endtask

   task automatic test_reset_midfetch();
      fetch_start = 1;
      tick();
      fetch_start = 0;
      tick(); tick();                // 3rd REQ cycle
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rstmid_pre: req %b want 1", imem_req); end
      #1 rst_n = 0;
      model_reset();
      #1;
      total++; if (imem_req !== 1'b0 || busy !== 1'b0) begin bad++;
         $display("FAIL rstmid_async: req %b busy %b want 0 0", imem_req, busy); end
      @(posedge clk); #1;
      rst_n = 1;
      tick();
      total++; if (pc !== RST_PC || ir !== 32'h0 || ir_pc !== 32'h0) begin bad++;
         $display("FAIL rstmid_regs: pc %h ir %h ir_pc %h want %h 0 0", pc, ir, ir_pc, RST_PC); end
      total++; if ({imem_req, ir_valid, busy, fetch_err, align_err} !== 5'b0) begin bad++;
         $display("FAIL rstmid_flags: got %b want 00000", {imem_req, ir_valid, busy, fetch_err, align_err}); end
   endtask

   task automatic test_random();
      int thr;
      logic [31:0] np;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) begin
            case ($urandom_range(0, 2))
               0: thr = 4;
               1: thr = 35;
               default: thr = 90;
            endcase
         end
         np = $urandom & 32'h0000_0FFC;
         if ($urandom_range(0, 3) == 0) np[1:0] = 2'($urandom_range(1, 3));
         next_pc     = np;
         pc_write    = ($urandom_range(0, 4) == 0);
         fetch_start = ($urandom_range(0, 3) == 0);
         imem_ack    = ($urandom_range(0, 99) < thr);
         imem_rdata  = $urandom;
         tick();
         total++; if (pc !== e_pc) begin bad++; $display("FAIL rnd_pc @%0d: got %h want %h", i, pc, e_pc); end
         total++; if (imem_req !== m_busy || busy !== m_busy) begin bad++;
            $display("FAIL rnd_req @%0d: req %b busy %b want %b", i, imem_req, busy, m_busy); end
         if (m_busy) begin
            total++; if (imem_addr !== e_pc) begin bad++; $display("FAIL rnd_addr @%0d: got %h want %h", i, imem_addr, e_pc); end
         end
         total++; if (ir !== e_ir || ir_pc !== e_ir_pc) begin bad++;
            $display("FAIL rnd_ir @%0d: ir %h ir_pc %h want %h %h", i, ir, ir_pc, e_ir, e_ir_pc); end
         total++; if (ir_valid !== e_ir_valid) begin bad++; $display("FAIL rnd_valid @%0d: got %b want %b", i, ir_valid, e_ir_valid); end
         total++; if (fetch_err !== e_fetch_err || align_err !== e_align_err) begin bad++;
            $display("FAIL rnd_err @%0d: fetch %b align %b want %b %b", i, fetch_err, align_err, e_fetch_err, e_align_err); end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_pc_write();
      test_delayed_ack();
      test_timeout();
      test_align();
      test_reset_midfetch();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
